// File: rtl/div_unit.sv
// Multicycle restoring divider for MIPS DIV/DIVU: one quotient bit per clock, sign fix-up at the end.
// Optional feature macro: DIV_UNSIGNED_EN adds the Unsigned select input for DIVU.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             StartDiv,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef DIV_UNSIGNED_EN
  input  logic             Unsigned,
`endif
  output logic [WIDTH-1:0] DivHigh,
  output logic [WIDTH-1:0] DivLow,
  output logic             DivStop,
  output logic             DivZero,
  output logic             DivBusy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

  stateT            state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] divisor;
  logic             negQuot;
  logic             negRem;

  logic             signedReq;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] remDiff;
  logic             canSub;

`ifdef DIV_UNSIGNED_EN
  assign signedReq = ~Unsigned;
`else
  assign signedReq = 1'b1;
`endif

  // Magnitudes stay WIDTH-bit unsigned, so the most negative value maps onto itself.
  // The shifted remainder needs one extra bit because an unsigned divisor may use the MSB.
  always_comb begin
    absA     = (signedReq && A[WIDTH-1]) ? -A : A;
    absB     = (signedReq && B[WIDTH-1]) ? -B : B;
    remShift = {rem, quot[WIDTH-1]};
    canSub   = remShift >= {1'b0, divisor};
    remDiff  = remShift[WIDTH-1:0] - divisor;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      count   <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      negQuot <= 1'b0;
      negRem  <= 1'b0;
      DivHigh <= '0;
      DivLow  <= '0;
      DivStop <= 1'b0;
      DivZero <= 1'b0;
      DivBusy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (StartDiv) begin
            negQuot <= signedReq & (A[WIDTH-1] ^ B[WIDTH-1]);
            negRem  <= signedReq & A[WIDTH-1];
            divisor <= absB;
            if (B == '0) begin
              DivZero <= 1'b1;
              DivStop <= 1'b1;
              state   <= DONE;
            end else begin
              DivZero <= 1'b0;
              quot    <= absA;
              rem     <= '0;
              count   <= CW'(WIDTH - 1);
              DivBusy <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= canSub ? remDiff : remShift[WIDTH-1:0];
          quot  <= {quot[WIDTH-2:0], canSub};
          count <= count - CW'(1);
          if (count == '0) state <= FIX;
        end
        FIX: begin
          DivLow  <= negQuot ? -quot : quot;
          DivHigh <= negRem ? -rem : rem;
          DivBusy <= 1'b0;
          DivStop <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          DivStop <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
